// File: rtl/param_fifo.sv
// Parametrised valid/ready FIFO with occupancy count, almost-full threshold and sticky overflow.
// Optional embedded properties are compiled in when PARAM_FIFO_ASSERT_EN is defined.

`ifdef PARAM_FIFO_ASSERT_EN
module param_fifo_chk #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic          clk,
    input logic          rst,
    input logic [AW-1:0] wr_ptr,
    input logic [AW-1:0] rd_ptr,
    input logic [AW:0]   count,
    input logic          in_ready,
    input logic          out_valid
);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_ZERO  = (AW+1)'(0);

    // Occupancy can never exceed the number of entries.
    p_count_bound: assert property (@(posedge clk) disable iff (rst) count <= L_DEPTH);

    // Output-valid is exactly "not empty".
    p_valid: assert property (@(posedge clk) disable iff (rst) out_valid == (count != L_ZERO));

    // Input-ready is exactly "out of reset and not full".
    p_ready: assert property (@(posedge clk) disable iff (rst) in_ready == (!rst && count != L_DEPTH));

    // Pointer distance agrees with occupancy modulo the depth.
    p_ptr: assert property (@(posedge clk) disable iff (rst) AW'(wr_ptr - rd_ptr) == count[AW-1:0]);

    // Overridden depth must be the power of two the pointer width implies.
    p_param: assert property (@(posedge clk) DEPTH == (1 << AW));
endmodule
`endif

module param_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    parameter  int AFULL = 3,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      count,
    output logic             almost_full,
    output logic             overflow
);
    localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_AFULL = (AW+1)'(AFULL);
    localparam logic [AW:0]   L_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]   L_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] L_PINC  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;

    // Handshake decode; ready is gated by rst so nothing is written in a reset cycle.
    always_comb begin
        in_ready    = !rst && (r_count != L_DEPTH);
        out_valid   = (r_count != L_ZERO);
        w_push      = in_valid && in_ready;
        w_pop       = out_valid && out_ready;
        almost_full = (r_count >= L_AFULL);
        out_data    = r_mem[r_rd_ptr];
        count       = r_count;
        overflow    = r_overflow;
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and sticky overflow with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= L_ZERO;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + L_PINC;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + L_PINC;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_ONE;
                2'b01:   r_count <= r_count - L_ONE;
                default: r_count <= r_count;
            endcase
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef PARAM_FIFO_ASSERT_EN
    param_fifo_chk #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .wr_ptr    (r_wr_ptr),
        .rd_ptr    (r_rd_ptr),
        .count     (r_count),
        .in_ready  (in_ready),
        .out_valid (out_valid)
    );
`endif
endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: a default 4-deep instance and a 16-bit, 8-deep, AFULL=6 override.
module tb_param_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        i4_valid = 1'b0, o4_ready = 1'b0;
    logic [7:0]  i4_data = 8'h00;
    logic        i4_ready, o4_valid, af4, ovf4;
    logic [7:0]  o4_data;
    logic [2:0]  cnt4;

    logic        i8_valid = 1'b0, o8_ready = 1'b0;
    logic [15:0] i8_data = 16'h0000;
    logic        i8_ready, o8_valid, af8, ovf8;
    logic [15:0] o8_data;
    logic [3:0]  cnt8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];
    logic        m_ovf4 = 1'b0;
    logic [1:0]  m_rd4  = 2'd0;

    param_fifo dut4 (
        .clk(clk), .rst(rst), .in_valid(i4_valid), .in_ready(i4_ready), .in_data(i4_data),
        .out_valid(o4_valid), .out_ready(o4_ready), .out_data(o4_data), .count(cnt4),
        .almost_full(af4), .overflow(ovf4)
    );

    param_fifo #(.WIDTH(16), .DEPTH(8), .AFULL(6)) dut8 (
        .clk(clk), .rst(rst), .in_valid(i8_valid), .in_ready(i8_ready), .in_data(i8_data),
        .out_valid(o8_valid), .out_ready(o8_ready), .out_data(o8_data), .count(cnt8),
        .almost_full(af8), .overflow(ovf8)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // One clock on the 4-deep instance; the bench model decides push/pop and keeps the scoreboard.
    task automatic tick4(input logic v, input logic [7:0] d, input logic r,
                         output logic popped, output logic [7:0] exp_d, output logic [7:0] got_d);
        int pre;
        i4_valid = v; i4_data = d; o4_ready = r;
        pre    = q4.size();
        got_d  = o4_data;
        popped = !rst && r && (pre != 0);
        exp_d  = 8'h00;
        if (popped) begin
            exp_d = q4.pop_front();
            m_rd4 = m_rd4 + 2'd1;
        end
        if (!rst && v && pre == 4) m_ovf4 = 1'b1;
        @(posedge clk); #1;
        if (rst) begin
            q4.delete(); m_ovf4 = 1'b0; m_rd4 = 2'd0;
        end else if (v && pre != 4) begin
            q4.push_back(d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q4.delete(); q8.delete(); m_ovf4 = 1'b0; m_rd4 = 2'd0;
        n_tests++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL reset_count4 got %0d required 0", cnt4); end
        n_tests++; if (o4_valid !== 1'b0 || af4 !== 1'b0 || ovf4 !== 1'b0) begin n_fail++; $display("FAIL reset_flags4 got v=%b af=%b ovf=%b required 0 0 0", o4_valid, af4, ovf4); end
        n_tests++; if (i4_ready !== 1'b0 || i8_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got %b %b required 0 0", i4_ready, i8_ready); end
        n_tests++; if (cnt8 !== 4'd0 || o8_valid !== 1'b0) begin n_fail++; $display("FAIL reset_state8 got cnt=%0d v=%b required 0 0", cnt8, o8_valid); end
        rst = 1'b0;
        #1;
        n_tests++; if (i4_ready !== 1'b1 || i8_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high got %b %b required 1 1", i4_ready, i8_ready); end
    endtask

    task automatic test_param_override();
        logic [15:0] got;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (i8_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_ready_%0d got %b required 1", i, i8_ready); end
            i8_valid = 1'b1; i8_data = 16'h1000 + 16'(i);
            q8.push_back(i8_data);
            @(posedge clk); #1;
            n_tests++; if (cnt8 !== 4'(i + 1)) begin n_fail++; $display("FAIL ovr_count_%0d got %0d required %0d", i, cnt8, i + 1); end
            n_tests++; if (af8 !== ((i + 1) >= 6)) begin n_fail++; $display("FAIL ovr_afull_%0d got %b required %b", i, af8, (i + 1) >= 6); end
        end
        i8_valid = 1'b0;
        n_tests++; if (i8_ready !== 1'b0) begin n_fail++; $display("FAIL ovr_ready_full got %b required 0", i8_ready); end
        o8_ready = 1'b1;
        while (q8.size() != 0) begin
            got = o8_data;
            n_tests++; if (got !== q8[0] || o8_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_pop got %h v=%b required %h v=1", got, o8_valid, q8[0]); end
            void'(q8.pop_front());
            @(posedge clk); #1;
        end
        o8_ready = 1'b0;
        n_tests++; if (cnt8 !== 4'd0 || o8_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained got cnt=%0d v=%b required 0 0", cnt8, o8_valid); end
    endtask

    task automatic test_defaults();
        logic p; logic [7:0] e, g;
        tick4(1'b1, 8'hA5, 1'b1, p, e, g);
        n_tests++; if (p !== 1'b0) begin n_fail++; $display("FAIL dflt_no_fallthrough got popped=%b required 0", p); end
        n_tests++; if (o4_valid !== 1'b1 || o4_data !== 8'hA5 || cnt4 !== 3'd1) begin n_fail++; $display("FAIL dflt_after_push got v=%b d=%h c=%0d required 1 a5 1", o4_valid, o4_data, cnt4); end
        tick4(1'b0, 8'h00, 1'b1, p, e, g);
        n_tests++; if (p !== 1'b1 || g !== e) begin n_fail++; $display("FAIL dflt_pop got %h required %h", g, e); end
        n_tests++; if (cnt4 !== 3'd0 || o4_valid !== 1'b0) begin n_fail++; $display("FAIL dflt_empty got c=%0d v=%b required 0 0", cnt4, o4_valid); end
    endtask

    task automatic test_wraparound();
        logic p; logic [7:0] e, g;
        int npop = 0;
        for (int i = 0; i <= 10; i++) begin
            tick4(i < 10, 8'(i), i > 0, p, e, g);
            if (p) begin
                n_tests++; if (g !== e || e !== 8'(npop)) begin n_fail++; $display("FAIL wrap_order_%0d got %h required %h", npop, g, npop); end
                npop++;
            end
            n_tests++; if (cnt4 > 3'd2 || cnt4 !== 3'(q4.size())) begin n_fail++; $display("FAIL wrap_count_%0d got %0d required %0d", i, cnt4, q4.size()); end
        end
        n_tests++; if (npop !== 10 || dut4.r_rd_ptr !== m_rd4) begin n_fail++; $display("FAIL wrap_total got pops=%0d rd=%0d required 10 %0d", npop, dut4.r_rd_ptr, m_rd4); end
    endtask

    task automatic test_full_pop();
        logic p; logic [7:0] e, g;
        for (int k = 1; k <= 4; k++) tick4(1'b1, 8'(k), 1'b0, p, e, g);
        n_tests++; if (cnt4 !== 3'd4 || i4_ready !== 1'b0 || af4 !== 1'b1) begin n_fail++; $display("FAIL full_state got c=%0d rdy=%b af=%b required 4 0 1", cnt4, i4_ready, af4); end
        tick4(1'b1, 8'd5, 1'b1, p, e, g);
        n_tests++; if (g !== 8'd1 || e !== 8'd1) begin n_fail++; $display("FAIL full_pop_head got %h required 01", g); end
        n_tests++; if (cnt4 !== 3'd3 || ovf4 !== 1'b1 || ovf4 !== m_ovf4) begin n_fail++; $display("FAIL full_after got c=%0d ovf=%b required 3 1", cnt4, ovf4); end
        for (int k = 0; k < 3; k++) begin
            tick4(1'b0, 8'h00, 1'b1, p, e, g);
            n_tests++; if (g !== e || e !== 8'(k + 2)) begin n_fail++; $display("FAIL full_drain_%0d got %h required %h", k, g, k + 2); end
        end
        n_tests++; if (o4_valid !== 1'b0 || cnt4 !== 3'd0) begin n_fail++; $display("FAIL full_no5 got v=%b c=%0d required 0 0", o4_valid, cnt4); end
    endtask

    task automatic test_reset_mid();
        logic p; logic [7:0] e, g;
        for (int k = 7; k <= 9; k++) tick4(1'b1, 8'(k), 1'b0, p, e, g);
        n_tests++; if (cnt4 !== 3'd3) begin n_fail++; $display("FAIL rmid_pre got %0d required 3", cnt4); end
        rst = 1'b1; #1;
        n_tests++; if (i4_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_rst got %b required 0", i4_ready); end
        tick4(1'b1, 8'h55, 1'b0, p, e, g);
        rst = 1'b0; #1;
        n_tests++; if (cnt4 !== 3'd0 || o4_valid !== 1'b0 || ovf4 !== 1'b0 || i4_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after got c=%0d v=%b ovf=%b rdy=%b required 0 0 0 1", cnt4, o4_valid, ovf4, i4_ready); end
        tick4(1'b1, 8'h66, 1'b0, p, e, g);
        n_tests++; if (o4_data !== 8'h66 || cnt4 !== 3'd1) begin n_fail++; $display("FAIL rmid_dropped got d=%h c=%0d required 66 1", o4_data, cnt4); end
        tick4(1'b0, 8'h00, 1'b1, p, e, g);
        n_tests++; if (g !== e || cnt4 !== 3'd0) begin n_fail++; $display("FAIL rmid_pop got %h required %h", g, e); end
    endtask

    task automatic test_empty_pop();
        logic p; logic [7:0] e, g;
        for (int k = 0; k < 5; k++) begin
            tick4(1'b0, 8'h00, 1'b1, p, e, g);
            n_tests++; if (cnt4 !== 3'd0 || o4_valid !== 1'b0 || p !== 1'b0 || dut4.r_rd_ptr !== m_rd4) begin n_fail++; $display("FAIL empty_pop_%0d got c=%0d v=%b rd=%0d required 0 0 %0d", k, cnt4, o4_valid, dut4.r_rd_ptr, m_rd4); end
        end
        o4_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_param_override();
        test_defaults();
        test_wraparound();
        test_full_pop();
        test_reset_mid();
        test_empty_pop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
